// File: rtl/pipelined_addsub_if.sv
// Operand/result handshake bundle for the pipelined adder/subtractor.
// The design is the slave; the producer/consumer side is the master.
interface pipelined_addsub_if #(
   parameter int unsigned WIDTH = 64
) ();
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             sub;
   logic             use_carry;
   logic             carry_in;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] result;
   logic             flag_n;
   logic             flag_z;
   logic             flag_c;
   logic             flag_v;

   modport slave (
      input  in_valid, a, b, sub, use_carry, carry_in, out_ready,
      output in_ready, out_valid, result, flag_n, flag_z, flag_c, flag_v
   );

   modport master (
      output in_valid, a, b, sub, use_carry, carry_in, out_ready,
      input  in_ready, out_valid, result, flag_n, flag_z, flag_c, flag_v
   );
endinterface

// File: rtl/pipelined_addsub.sv
// Chunked carry-pipelined WIDTH-bit add/sub with NZCV flags; stage k sums chunk k.
// All stages advance together when the output slot is free or being drained.
module pipelined_addsub #(
   parameter int unsigned WIDTH  = 64,
   parameter int unsigned STAGES = 4
) (
   input  logic               clk,
   input  logic               reset,
   pipelined_addsub_if.slave  io
);
   localparam int unsigned CW   = WIDTH / STAGES;
   localparam int unsigned LAST = STAGES - 1;

   if ((WIDTH % STAGES) != 0) begin : g_bad_split
      $error("pipelined_addsub: WIDTH must be a multiple of STAGES");
   end

   logic             w_adv;
   logic [WIDTH-1:0] w_beff;
   logic             w_cin0;

   assign w_beff      = io.sub ? ~io.b : io.b;
   assign w_cin0      = io.use_carry ? io.carry_in : io.sub;
   assign io.in_ready = w_adv;

   // r_word holds result bits for chunks already summed and raw A above them
   for (genvar k = 0; k < STAGES; k++) begin : g_stage
      logic [WIDTH-1:0] w_word_in;
      logic [CW-1:0]    w_bchunk;
      logic             w_cin;
      logic             w_zin;
      logic             w_vin;
      logic [CW:0]      w_sum;
      logic [WIDTH-1:0] w_word;

      logic             r_vld;
      logic             r_cy;
      logic             r_z;
      logic [WIDTH-1:0] r_word;

      if (k == 0) begin : g_first
         assign w_word_in = io.a;
         assign w_bchunk  = w_beff[CW-1:0];
         assign w_cin     = w_cin0;
         assign w_zin     = 1'b1;
         assign w_vin     = io.in_valid;
      end else begin : g_next
         assign w_word_in = g_stage[k-1].r_word;
         assign w_bchunk  = g_stage[k-1].g_brem.r_b[CW-1:0];
         assign w_cin     = g_stage[k-1].r_cy;
         assign w_zin     = g_stage[k-1].r_z;
         assign w_vin     = g_stage[k-1].r_vld;
      end

      assign w_sum = {1'b0, w_word_in[k*CW +: CW]} + {1'b0, w_bchunk} + (CW+1)'(w_cin);

      always_comb begin
         w_word                = w_word_in;
         w_word[k*CW +: CW]    = w_sum[CW-1:0];
      end

      always_ff @(posedge clk or posedge reset) begin
         if (reset) begin
            r_vld  <= 1'b0;
            r_cy   <= 1'b0;
            r_z    <= 1'b0;
            r_word <= '0;
         end else if (w_adv) begin
            r_vld <= w_vin;
            if (w_vin) begin
               r_word <= w_word;
               r_cy   <= w_sum[CW];
               r_z    <= w_zin & ~(|w_sum[CW-1:0]);
            end
         end
      end

      // B_eff chunks still waiting to be summed by later stages
      if (k < LAST) begin : g_brem
         logic [(LAST-k)*CW-1:0] w_b_nxt;
         logic [(LAST-k)*CW-1:0] r_b;

         if (k == 0) begin : g_src_in
            assign w_b_nxt = w_beff[WIDTH-1:CW];
         end else begin : g_src_prev
            assign w_b_nxt = g_stage[k-1].g_brem.r_b[(LAST-k+1)*CW-1:CW];
         end

         always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
               r_b <= '0;
            end else if (w_adv && w_vin) begin
               r_b <= w_b_nxt;
            end
         end
      end

      // Overflow from the MSB cell: carry into MSB recovered as a ^ b ^ sum
      if (k == LAST) begin : g_last
         logic w_v;
         logic r_v;

         assign w_v = w_word_in[WIDTH-1] ^ w_bchunk[CW-1] ^ w_sum[CW-1] ^ w_sum[CW];

         always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
               r_v <= 1'b0;
            end else if (w_adv && w_vin) begin
               r_v <= w_v;
            end
         end

         assign w_adv        = io.out_ready | ~r_vld;
         assign io.out_valid = r_vld;
         assign io.result    = r_word;
         assign io.flag_n    = r_word[WIDTH-1];
         assign io.flag_z    = r_z;
         assign io.flag_c    = r_cy;
         assign io.flag_v    = r_v;
      end
   end
endmodule

// File: tb/tb_pipelined_addsub.sv
// Directed vector table, streaming/backpressure and reset-flush sequences on a
// 4-stage instance, plus random scoreboarded runs on 1- and 8-stage instances.
module tb_pipelined_addsub;
   localparam int unsigned W = 64;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   pipelined_addsub_if #(.WIDTH(W)) if4 ();
   pipelined_addsub_if #(.WIDTH(W)) if1 ();
   pipelined_addsub_if #(.WIDTH(W)) if8 ();

   pipelined_addsub #(.WIDTH(W), .STAGES(4)) dut4 (.clk(clk), .reset(reset), .io(if4));
   pipelined_addsub #(.WIDTH(W), .STAGES(1)) dut1 (.clk(clk), .reset(reset), .io(if1));
   pipelined_addsub #(.WIDTH(W), .STAGES(8)) dut8 (.clk(clk), .reset(reset), .io(if8));

   typedef struct {
      logic [63:0] a;
      logic [63:0] b;
      logic        sub;
      logic        uc;
      logic        cin;
      logic [63:0] res;
      logic [3:0]  nzcv;
   } vec_t;

   typedef struct packed {
      logic [63:0] res;
      logic        n;
      logic        z;
      logic        c;
      logic        v;
   } exp_t;

   int   n_checks = 0;
   int   n_errors = 0;
   vec_t vecs[13];
   exp_t q1[$];
   exp_t q8[$];

   function automatic exp_t model(input logic [63:0] a, input logic [63:0] b,
                                  input logic sub, input logic uc, input logic cin);
      exp_t        e;
      logic [63:0] be;
      logic [64:0] s;
      be    = sub ? ~b : b;
      s     = {1'b0, a} + {1'b0, be} + 65'(uc ? cin : sub);
      e.res = s[63:0];
      e.n   = s[63];
      e.z   = (s[63:0] == 64'd0);
      e.c   = s[64];
      e.v   = (a[63] == be[63]) && (s[63] != a[63]);
      return e;
   endfunction

   task automatic chk(input string name, input logic [67:0] act, input logic [67:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // One isolated beat on the 4-stage instance; returns latency in cycles (0 = timeout)
   task automatic run_one(input logic [63:0] a, input logic [63:0] b, input logic sub,
                          input logic uc, input logic cin, output int lat,
                          output logic [63:0] res, output logic [3:0] f);
      if4.in_valid  = 1'b1;
      if4.a         = a;
      if4.b         = b;
      if4.sub       = sub;
      if4.use_carry = uc;
      if4.carry_in  = cin;
      if4.out_ready = 1'b1;
      @(negedge clk);
      chk("accept_ready", 68'(if4.in_ready), 68'(1));
      @(posedge clk);
      #1 if4.in_valid = 1'b0;
      lat = 0;
      for (int n = 1; n <= 12; n++) begin
         @(negedge clk);
         if (if4.out_valid) begin
            lat = n;
            break;
         end
      end
      res = if4.result;
      f   = {if4.flag_n, if4.flag_z, if4.flag_c, if4.flag_v};
      @(posedge clk);
      #1;
   endtask

   initial begin
      int          lat;
      logic [63:0] res;
      logic [3:0]  f;
      int          acc;
      int          got;
      int          cnt;
      logic        stall;
      logic [63:0] held;
      logic [63:0] ra;
      logic [63:0] rb;
      logic        rs;
      logic        ru;
      logic        rc;
      int          mode;
      exp_t        e;

      vecs[0]  = '{64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0, 1'b0, 64'd0,                 4'b0110};
      vecs[1]  = '{64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0, 1'b0, 64'h8000_0000_0000_0000, 4'b1001};
      vecs[2]  = '{64'd5, 64'd7, 1'b1, 1'b0, 1'b0, 64'hFFFF_FFFF_FFFF_FFFE,                  4'b1000};
      vecs[3]  = '{64'd7, 64'd5, 1'b1, 1'b0, 1'b0, 64'd2,                                    4'b0010};
      vecs[4]  = '{64'd5, 64'd5, 1'b1, 1'b0, 1'b0, 64'd0,                                    4'b0110};
      vecs[5]  = '{64'h8000_0000_0000_0000, 64'd1, 1'b1, 1'b0, 1'b0, 64'h7FFF_FFFF_FFFF_FFFF, 4'b0011};
      vecs[6]  = '{64'h0000_0000_FFFF_FFFF, 64'd1, 1'b0, 1'b0, 1'b0, 64'h0000_0001_0000_0000, 4'b0000};
      vecs[7]  = '{64'h0000_0000_0000_FFFF, 64'd0, 1'b0, 1'b1, 1'b1, 64'h0000_0000_0001_0000, 4'b0000};
      vecs[8]  = '{64'd10, 64'd3, 1'b1, 1'b1, 1'b0, 64'd6,                                   4'b0010};
      vecs[9]  = '{64'd0, 64'd0, 1'b1, 1'b0, 1'b0, 64'd0,                                    4'b0110};
      vecs[10] = '{64'd0, 64'd0, 1'b0, 1'b0, 1'b0, 64'd0,                                    4'b0100};
      vecs[11] = '{64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0, 1'b0, 1'b0, 64'd0, 4'b0111};
      vecs[12] = '{64'd3, 64'd10, 1'b1, 1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FFF9,                 4'b1000};

      if4.in_valid = 1'b0; if4.a = '0; if4.b = '0; if4.sub = 1'b0;
      if4.use_carry = 1'b0; if4.carry_in = 1'b0; if4.out_ready = 1'b1;
      if1.in_valid = 1'b0; if1.a = '0; if1.b = '0; if1.sub = 1'b0;
      if1.use_carry = 1'b0; if1.carry_in = 1'b0; if1.out_ready = 1'b1;
      if8.in_valid = 1'b0; if8.a = '0; if8.b = '0; if8.sub = 1'b0;
      if8.use_carry = 1'b0; if8.carry_in = 1'b0; if8.out_ready = 1'b1;

      // Reset state
      reset = 1'b1;
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      chk("rst_out_valid", 68'(if4.out_valid), 68'(0));
      chk("rst_result", 68'(if4.result), 68'(0));
      chk("rst_flags", 68'({if4.flag_n, if4.flag_z, if4.flag_c, if4.flag_v}), 68'(0));
      chk("rst_in_ready", 68'(if4.in_ready), 68'(1));
      @(posedge clk);
      #1;

      // Directed vector table
      foreach (vecs[i]) begin
         run_one(vecs[i].a, vecs[i].b, vecs[i].sub, vecs[i].uc, vecs[i].cin, lat, res, f);
         chk($sformatf("vec%0d_latency", i), 68'(lat), 68'(4));
         chk($sformatf("vec%0d_result", i), 68'(res), 68'(vecs[i].res));
         chk($sformatf("vec%0d_nzcv", i), 68'(f), 68'(vecs[i].nzcv));
      end

      // Back-to-back stream with a three-cycle output stall while the pipe is full
      acc = 0;
      got = 0;
      held = '0;
      for (int c = 0; c < 40 && got < 8; c++) begin
         if4.in_valid  = (acc < 8);
         if4.a         = 64'(acc);
         if4.b         = 64'(acc);
         if4.sub       = 1'b0;
         if4.use_carry = 1'b1;
         if4.carry_in  = acc[0];
         stall         = (c >= 6) && (c <= 8);
         if4.out_ready = ~stall;
         @(negedge clk);
         if (stall) begin
            chk("stall_in_ready", 68'(if4.in_ready), 68'(0));
            chk("stall_out_valid", 68'(if4.out_valid), 68'(1));
            if (c == 6) held = if4.result;
            else chk("stall_hold", 68'(if4.result), 68'(held));
         end else begin
            chk("run_in_ready", 68'(if4.in_ready), 68'(1));
         end
         if (if4.out_valid && if4.out_ready) begin
            chk($sformatf("stream_res%0d", got), 68'(if4.result), 68'(2 * got + (got % 2)));
            got++;
         end
         if (if4.in_valid && if4.in_ready) acc++;
         @(posedge clk);
         #1;
      end
      if4.in_valid  = 1'b0;
      if4.out_ready = 1'b1;
      chk("stream_count", 68'(got), 68'(8));
      cnt = 0;
      repeat (6) begin
         @(negedge clk);
         if (if4.out_valid) cnt++;
         @(posedge clk);
         #1;
      end
      chk("stream_no_dup", 68'(cnt), 68'(0));

      // Reset with three beats in flight
      for (int i = 0; i < 3; i++) begin
         if4.in_valid = 1'b1;
         if4.a = 64'(100 + i);
         if4.b = 64'd1;
         if4.sub = 1'b0;
         if4.use_carry = 1'b0;
         @(posedge clk);
         #1;
      end
      if4.in_valid = 1'b0;
      reset = 1'b1;
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      chk("flush_result", 68'(if4.result), 68'(0));
      cnt = 0;
      repeat (8) begin
         @(negedge clk);
         if (if4.out_valid) cnt++;
         @(posedge clk);
         #1;
      end
      chk("flush_no_beat", 68'(cnt), 68'(0));
      run_one(64'h1234, 64'h1111, 1'b1, 1'b0, 1'b0, lat, res, f);
      chk("post_rst_latency", 68'(lat), 68'(4));
      chk("post_rst_result", 68'(res), 68'(64'h0123));
      chk("post_rst_nzcv", 68'(f), 68'(4'b0010));

      // Random scoreboard on the 1-stage and 8-stage instances
      for (int i = 0; i < 1000 + 12; i++) begin
         if (i < 1000) begin
            ra   = {$urandom, $urandom};
            rb   = {$urandom, $urandom};
            mode = $urandom_range(0, 3);
            if (mode == 0) rb = ~ra;
            else if (mode == 1) rb = ra;
            rs = 1'($urandom_range(0, 1));
            ru = 1'($urandom_range(0, 1));
            rc = 1'($urandom_range(0, 1));
         end
         if1.in_valid = (i < 1000); if1.a = ra; if1.b = rb;
         if1.sub = rs; if1.use_carry = ru; if1.carry_in = rc;
         if8.in_valid = (i < 1000); if8.a = ra; if8.b = rb;
         if8.sub = rs; if8.use_carry = ru; if8.carry_in = rc;
         @(negedge clk);
         if (if1.out_valid) begin
            if (q1.size() == 0) chk("s1_extra_beat", 68'(1), 68'(0));
            else begin
               e = q1.pop_front();
               chk("s1_beat", {if1.result, if1.flag_n, if1.flag_z, if1.flag_c, if1.flag_v}, e);
            end
         end
         if (if8.out_valid) begin
            if (q8.size() == 0) chk("s8_extra_beat", 68'(1), 68'(0));
            else begin
               e = q8.pop_front();
               chk("s8_beat", {if8.result, if8.flag_n, if8.flag_z, if8.flag_c, if8.flag_v}, e);
            end
         end
         if (i < 1000) begin
            e = model(ra, rb, rs, ru, rc);
            q1.push_back(e);
            q8.push_back(e);
         end
         @(posedge clk);
         #1;
      end
      chk("s1_drained", 68'(q1.size()), 68'(0));
      chk("s8_drained", 68'(q8.size()), 68'(0));

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
